// File: rtl/if_stage.sv
// Instruction fetch stage.
// Keeps the fetch PC, issues instruction SRAM reads and presents {pc, inst}
// to decode. A redirect that arrives while fetch is stalled is held as a
// pending target and applied by the next SRAM read.
// When the macro IF_INST_BUF_EN is defined, a one-entry buffer holds the
// instruction during a decode stall, so the SRAM output need not hold.
// When it is undefined, the SRAM must hold its read data while en = 0.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  // Chosen so that the first sequential fetch lands on 0x1C000000.
  localparam logic [31:0] ResetPc = 32'h1BFF_FFFC;

  logic        r_fs_valid;
  logic [31:0] r_fs_pc;
  logic        r_br_pend;
  logic [31:0] r_pend_target;

  logic        w_to_fs_valid;
  logic        w_fs_allowin;
  logic [31:0] w_seq_pc;
  logic [31:0] w_nextpc;
  logic [31:0] w_fs_inst;

  assign w_to_fs_valid = ~reset;
  assign w_fs_allowin  = ~r_fs_valid | ds_allowin;
  assign w_seq_pc      = r_fs_pc + 32'd4;

  // A fresh redirect beats an older pending one.
  assign w_nextpc = br_taken  ? br_target     :
                    r_br_pend ? r_pend_target :
                                w_seq_pc;

  assign inst_sram_en    = w_to_fs_valid & w_fs_allowin;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_addr  = w_nextpc;
  assign inst_sram_wdata = 32'd0;

  // The held instruction is wrong-path while any redirect is in flight.
  assign fs_to_ds_valid = r_fs_valid & ~br_taken & ~r_br_pend & ~reset;
  assign fs_to_ds_bus   = {r_fs_pc, w_fs_inst};

  // Fetch PC and valid advance only when a read is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fs_valid <= 1'b0;
      r_fs_pc    <= ResetPc;
    end else if (inst_sram_en) begin
      r_fs_valid <= 1'b1;
      r_fs_pc    <= w_nextpc;
    end
  end

  // Park a redirect that cannot be fetched yet; the next issued read consumes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_br_pend     <= 1'b0;
      r_pend_target <= 32'd0;
    end else if (br_taken && !w_fs_allowin) begin
      r_br_pend     <= 1'b1;
      r_pend_target <= br_target;
    end else if (inst_sram_en) begin
      r_br_pend     <= 1'b0;
    end
  end

`ifdef IF_INST_BUF_EN
  logic        r_buf_valid;
  logic [31:0] r_inst_buf;

  // Capture the SRAM data on the first stalled cycle; release once fetch moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_valid <= 1'b0;
      r_inst_buf  <= 32'd0;
    end else if (w_fs_allowin) begin
      r_buf_valid <= 1'b0;
    end else if (r_fs_valid && !ds_allowin && !r_buf_valid) begin
      r_buf_valid <= 1'b1;
      r_inst_buf  <= inst_sram_rdata;
    end
  end

  assign w_fs_inst = r_buf_valid ? r_inst_buf : inst_sram_rdata;
`else
  assign w_fs_inst = inst_sram_rdata;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a per-cycle vector table followed by
// hand-written sequences for reset-during-redirect, PC wrap and reset mid-stall.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] accepted[$];

  if_stage u_dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_A5A5;
  endfunction

  // Synchronous-read SRAM; output holds while not enabled unless the stall
  // buffer is built in, in which case it is deliberately corrupted.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_of(inst_sram_addr);
`ifdef IF_INST_BUF_EN
    else inst_sram_rdata <= 32'hDEAD_BEEF;
`endif
  end

  typedef struct {
    logic        rst;
    logic        ds;
    logic        br;
    logic [31:0] tgt;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic ds, input logic br,
                              input logic [31:0] tgt, input logic en,
                              input logic [31:0] addr, input logic vld,
                              input logic [31:0] pc);
    vec_t v;
    v.rst = rst; v.ds = ds; v.br = br; v.tgt = tgt;
    v.en = en; v.addr = addr; v.vld = vld; v.pc = pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, then check outputs.
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    reset      = v.rst;
    ds_allowin = v.ds;
    br_taken   = v.br;
    br_target  = v.tgt;
    #1;
    check({tag, " en"},    {63'd0, inst_sram_en},   {63'd0, v.en});
    check({tag, " addr"},  {32'd0, inst_sram_addr}, {32'd0, v.addr});
    check({tag, " valid"}, {63'd0, fs_to_ds_valid}, {63'd0, v.vld});
    check({tag, " we"},    {63'd0, inst_sram_we},   64'd0);
    check({tag, " wdata"}, {32'd0, inst_sram_wdata}, 64'd0);
    if (v.vld) check({tag, " bus"}, fs_to_ds_bus, {v.pc, inst_of(v.pc)});
    if (fs_to_ds_valid && ds_allowin) accepted.push_back(fs_to_ds_bus[63:32]);
  endtask

  vec_t        vecs[23];
  logic [31:0] exp_acc[10];

  initial begin
    vecs[0]  = mk(1, 1, 0, 32'h0,         0, 32'h1C00_0000, 0, 32'h0);
    vecs[1]  = mk(0, 1, 0, 32'h0,         1, 32'h1C00_0000, 0, 32'h0);
    vecs[2]  = mk(0, 1, 0, 32'h0,         1, 32'h1C00_0004, 1, 32'h1C00_0000);
    vecs[3]  = mk(0, 1, 0, 32'h0,         1, 32'h1C00_0008, 1, 32'h1C00_0004);
    vecs[4]  = mk(0, 1, 1, 32'h1C00_0100, 1, 32'h1C00_0100, 0, 32'h0);
    vecs[5]  = mk(0, 1, 0, 32'h0,         1, 32'h1C00_0104, 1, 32'h1C00_0100);
    vecs[6]  = mk(0, 1, 1, 32'h1C00_000C, 1, 32'h1C00_000C, 0, 32'h0);
    vecs[7]  = mk(0, 1, 0, 32'h0,         1, 32'h1C00_0010, 1, 32'h1C00_000C);
    vecs[8]  = mk(0, 0, 0, 32'h0,         0, 32'h1C00_0014, 1, 32'h1C00_0010);
    vecs[9]  = mk(0, 0, 0, 32'h0,         0, 32'h1C00_0014, 1, 32'h1C00_0010);
    vecs[10] = mk(0, 0, 0, 32'h0,         0, 32'h1C00_0014, 1, 32'h1C00_0010);
    vecs[11] = mk(0, 1, 0, 32'h0,         1, 32'h1C00_0014, 1, 32'h1C00_0010);
    vecs[12] = mk(0, 0, 0, 32'h0,         0, 32'h1C00_0018, 1, 32'h1C00_0014);
    vecs[13] = mk(0, 0, 1, 32'h1C00_0200, 0, 32'h1C00_0200, 0, 32'h0);
    vecs[14] = mk(0, 0, 0, 32'h0,         0, 32'h1C00_0200, 0, 32'h0);
    vecs[15] = mk(0, 1, 0, 32'h0,         1, 32'h1C00_0200, 0, 32'h0);
    vecs[16] = mk(0, 1, 0, 32'h0,         1, 32'h1C00_0204, 1, 32'h1C00_0200);
    vecs[17] = mk(0, 0, 0, 32'h0,         0, 32'h1C00_0208, 1, 32'h1C00_0204);
    vecs[18] = mk(0, 0, 1, 32'h1C00_0200, 0, 32'h1C00_0200, 0, 32'h0);
    vecs[19] = mk(0, 0, 1, 32'h1C00_0300, 0, 32'h1C00_0300, 0, 32'h0);
    vecs[20] = mk(0, 0, 0, 32'h0,         0, 32'h1C00_0300, 0, 32'h0);
    vecs[21] = mk(0, 1, 0, 32'h0,         1, 32'h1C00_0300, 0, 32'h0);
    vecs[22] = mk(0, 1, 0, 32'h0,         1, 32'h1C00_0304, 1, 32'h1C00_0300);

    exp_acc = '{32'h1C00_0000, 32'h1C00_0004, 32'h1C00_0100, 32'h1C00_000C,
                32'h1C00_0010, 32'h1C00_0200, 32'h1C00_0300, 32'h1C00_0000,
                32'hFFFF_FFFC, 32'h1C00_0000};

    reset      = 1'b1;
    ds_allowin = 1'b1;
    br_taken   = 1'b0;
    br_target  = 32'h0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 23; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Reset while a redirect is pending: the pending target must be discarded.
    apply("rstpend_stall",  mk(0, 0, 0, 32'h0,         0, 32'h1C00_0308, 1, 32'h1C00_0304));
    apply("rstpend_br",     mk(0, 0, 1, 32'h1C00_0400, 0, 32'h1C00_0400, 0, 32'h0));
    apply("rstpend_rst",    mk(1, 0, 0, 32'h0,         0, 32'h1C00_0400, 0, 32'h0));
    apply("rstpend_first",  mk(0, 1, 0, 32'h0,         1, 32'h1C00_0000, 0, 32'h0));
    apply("rstpend_second", mk(0, 1, 0, 32'h0,         1, 32'h1C00_0004, 1, 32'h1C00_0000));

    // Sequential PC wraps from 0xFFFFFFFC to 0.
    apply("wrap_br",   mk(0, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0));
    apply("wrap_next", mk(0, 1, 0, 32'h0,         1, 32'h0000_0000, 1, 32'hFFFF_FFFC));

    // Reset during a plain stall with a valid instruction held.
    apply("rststall_hold",  mk(0, 0, 0, 32'h0, 0, 32'h0000_0004, 1, 32'h0000_0000));
    apply("rststall_rst",   mk(1, 0, 0, 32'h0, 0, 32'h0000_0004, 0, 32'h0));
    apply("rststall_first", mk(0, 1, 0, 32'h0, 1, 32'h1C00_0000, 0, 32'h0));
    apply("rststall_next",  mk(0, 1, 0, 32'h0, 1, 32'h1C00_0004, 1, 32'h1C00_0000));

    // Every correct-path instruction reaches decode exactly once, in order.
    check("accept_count", 64'(accepted.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < accepted.size())
        check($sformatf("accept%0d", i), {32'd0, accepted[i]}, {32'd0, exp_acc[i]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; `clk` and `reset` are listed first below.
REQ-002 Port `clk`  input  1  is the core clock; all state updates on the rising edge.
REQ-003 Port `reset`  input  1  is the synchronous active-high reset.
REQ-004 Port `ds_allowin`  input  1  means decode can accept an instruction this cycle.
REQ-005 Port `br_taken`  input  1  is a one-cycle redirect pulse from decode.
REQ-006 Port `br_target`  input  32  is the redirect PC, valid with `br_taken`.
REQ-007 Port `fs_to_ds_valid`  output  1  means the fetched instruction is valid toward decode.
REQ-008 Port `fs_to_ds_bus`  output  64  carries {fs_pc[31:0], fs_inst[31:0]}.
REQ-009 Port `inst_sram_en`  output  1  is the instruction SRAM read enable.
REQ-010 Port `inst_sram_we`  output  1  is the instruction SRAM write enable and is tied to 0.
REQ-011 Port `inst_sram_addr`  output  32  is the instruction SRAM address.
REQ-012 Port `inst_sram_wdata`  output  32  is the instruction SRAM write data and is tied to 0.
REQ-013 Port `inst_sram_rdata`  input  32  is the read data, returned one cycle after the address is accepted.

Function
REQ-014 seq_pc SHALL equal fs_pc + 4, with 32-bit wrap (0xFFFFFFFC + 4 = 0x00000000).
REQ-015 nextpc SHALL be selected in priority order: br_target when `br_taken`; else the pending target when br_pend = 1; else seq_pc.
REQ-016 to_fs_valid SHALL equal ~reset.
REQ-017 fs_allowin SHALL equal ~fs_valid | ds_allowin (fs_ready_go = 1).
REQ-018 inst_sram_en SHALL equal to_fs_valid & fs_allowin, and inst_sram_addr SHALL equal nextpc (combinational).
REQ-019 When inst_sram_en = 1: fs_valid <= 1 and fs_pc <= nextpc at the clock edge.
REQ-020 When fs_allowin = 0, fs_valid and fs_pc SHALL hold.
REQ-021 fs_to_ds_valid SHALL equal fs_valid & ~br_taken & ~br_pend, so the wrong-path instruction is never presented to decode.
REQ-022 Redirect while stalled: if br_taken = 1 and fs_allowin = 0, then br_pend <= 1 and pend_target <= br_target.
REQ-023 br_pend SHALL clear on the first cycle in which inst_sram_en = 1; that fetch uses pend_target.
REQ-024 When br_taken and br_pend are both active, br_taken SHALL win and pend_target SHALL be overwritten.
REQ-025 fs_inst SHALL equal inst_sram_rdata, or the buffered value as defined in REQ-029.
REQ-026 No instruction SHALL be duplicated or dropped on the correct path.

Reset
REQ-027 While reset = 1: fs_valid = 0, fs_pc = 0x1BFFFFFC, br_pend = 0, pend_target = 0, and the instruction buffer is empty.
REQ-028 Outputs SHALL be fs_to_ds_valid = 0 and inst_sram_en = 0 during reset; the first fetch after reset deasserts issues inst_sram_addr = 0x1C000000 in that same cycle.
- Reset asserted mid-stall or with a branch pending discards all state within one edge.

Configuration
REQ-029 Macro IF_INST_BUF_EN SHALL control a stall buffer.
- Defined: on the first cycle with fs_valid & ~ds_allowin, capture inst_sram_rdata into inst_buf and set buf_valid; fs_inst = buf_valid ? inst_buf : inst_sram_rdata; buf_valid clears when fs_allowin = 1 or on reset.
- Undefined: fs_inst = inst_sram_rdata directly; the SRAM is required to hold its output while en = 0.

Verification
REQ-030 Reset release, ds_allowin = 1: inst_sram_addr = 0x1C000000, then 0x1C000004, 0x1C000008; fs_to_ds_bus PCs follow one cycle later.
REQ-031 br_taken pulse with br_target = 0x1C000100 while fs_pc = 0x1C000008: fs_to_ds_valid = 0 that cycle; the next fetch address is 0x1C000100.
REQ-032 ds_allowin = 0 for 3 cycles while fs_pc = 0x1C000010: inst_sram_en = 0, fs_pc holds, and the same instruction is delivered once when ds_allowin returns (SRAM output corrupted during the stall when IF_INST_BUF_EN is defined).
REQ-033 br_taken with target 0x1C000200 while ds_allowin = 0: br_pend = 1 and fs_to_ds_valid = 0; on release, the fetch address is 0x1C000200 and br_pend = 0.
REQ-034 br_taken at target 0x1C000300 while br_pend holds 0x1C000200: the fetch goes to 0x1C000300.
REQ-035 Reset asserted during a pending redirect: the next fetch after release is 0x1C000000.
